// File: rtl/spi_slave_tx_fifo.sv
// Transmit FIFO feeding spi_slave: circular buffer with a registered 1-cycle read,
// fill count, almost-full/full/empty decode, overflow/underflow pulses and flush.
module spi_slave_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_en,
  input  logic                      flush,
  output logic                      full,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      fifo_req_data,
  output logic [DATA_WIDTH-1:0]     fifo_din,
  output logic                      fifo_din_valid,
  output logic                      fifo_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  din_valid_q, din_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic is_empty, is_full;
  logic rd_ok, wr_ok;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_ok = fifo_req_data && !is_empty && !flush;
  assign wr_ok = wr_en && !flush && (!is_full || rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    din_d       = din_q;
    din_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      overflow_d  = wr_en && is_full && !rd_ok;
      underflow_d = fifo_req_data && is_empty;
      if (rd_ok) begin
        din_d       = mem[rd_ptr_q];
        din_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + AW'(1);
      end
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; read-before-write ordering falls out of the nonblocking update.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign count          = count_q;
  assign full           = is_full;
  assign fifo_empty     = is_empty;
  assign almost_full    = (count_q >= AF_CNT);
  assign fifo_din       = din_q;
  assign fifo_din_valid = din_valid_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Bench for spi_slave_tx_fifo: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_spi_slave_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          flush = 1'b0;
  logic          full, almost_full, overflow, underflow;
  logic [4:0]    count;
  logic          fifo_req_data = 1'b0;
  logic [DW-1:0] fifo_din;
  logic          fifo_din_valid, fifo_empty;

  spi_slave_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
    .full(full), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow),
    .fifo_req_data(fifo_req_data), .fifo_din(fifo_din),
    .fifo_din_valid(fifo_din_valid), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_din = '0;
  logic          exp_valid = 1'b0, exp_ov = 1'b0, exp_un = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned sz;
    sz = mq.size();
    check({tag, ".count"}, 32'(count), sz);
    check({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
    check({tag, ".afull"}, 32'(almost_full), 32'(sz >= AFL));
    check({tag, ".empty"}, 32'(fifo_empty), 32'(sz == 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ov));
    check({tag, ".unf"}, 32'(underflow), 32'(exp_un));
    check({tag, ".valid"}, 32'(fifo_din_valid), 32'(exp_valid));
    check({tag, ".din"}, 32'(fifo_din), 32'(exp_din));
  endtask

  // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic f);
    int unsigned sz;
    logic rd;
    wr_en = w; wr_data = d; fifo_req_data = r; flush = f;
    sz = mq.size();
    if (f) begin
      mq.delete();
      exp_valid = 1'b0; exp_ov = 1'b0; exp_un = 1'b0;
    end else begin
      rd        = r && (sz > 0);
      exp_un    = r && (sz == 0);
      exp_ov    = w && (sz == DEPTH) && !rd;
      exp_valid = rd;
      if (rd) exp_din = mq.pop_front();
      if (w && (sz < DEPTH || rd)) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; fifo_req_data = 1'b0; flush = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_din = '0; exp_valid = 1'b0; exp_ov = 1'b0; exp_un = 1'b0;
  endtask

  initial begin
    int unsigned pw, pr;
    logic [DW-1:0] d;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // 1: single word round trip
    step("t1_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("t1_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_din_a5", 32'(fifo_din), 32'hA5);
    step("t1_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // 2: fill, overflow, drain
    for (int i = 0; i < 16; i++) step("t2_fill", 1'b1, DW'(i), 1'b0, 1'b0);
    step("t2_ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("t2_ovf_pulse", 32'(overflow), 32'd1);
    step("t2_ovf_end", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step("t2_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 3: full with simultaneous write and read (refill first)
    step("t3_pre", 1'b1, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step("t3_fill", 1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    check("t3_full", 32'(full), 32'd1);
    step("t3_wr_rd", 1'b1, 8'h77, 1'b1, 1'b0);
    check("t3_cnt16", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) step("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_last", 32'(fifo_din), 32'h77);

    // 4: write + read on empty
    step("t4_wr_rd", 1'b1, 8'h3C, 1'b1, 1'b0);
    check("t4_unf", 32'(underflow), 32'd1);
    step("t4_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_din", 32'(fifo_din), 32'h3C);

    // 5: wrap-around pairs
    for (int i = 0; i < 40; i++) begin
      step("t5_wr", 1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      check("t5_cnt_le1", 32'(count <= 5'd1), 32'd1);
      step("t5_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // 6: flush priority, then async reset mid-burst
    for (int i = 0; i < 5; i++) step("t6_fill", 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    step("t6_flush", 1'b1, 8'hEE, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("t6_refill", 1'b1, DW'(8'hD0 + i), 1'b0, 1'b0);
    step("t6_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    @(posedge clk);
    #1;
    check_all("t6_rst_hold");
    rst = 1'b1;

    // Random traffic in phases biased toward filling, balance, and draining
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0:       begin pw = 85; pr = 25; end
        1:       begin pw = 50; pr = 50; end
        default: begin pw = 20; pr = 80; end
      endcase
      for (int i = 0; i < 80; i++) begin
        d = DW'($urandom);
        step("rnd", ($urandom_range(0, 99) < pw), d, ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 99) < 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
